// File: rtl/pixel_classifier.sv
// pixel_classifier: YCrCb chroma-box classifier with a per-line run
// filter and an inter-frame window for the marker-tracking stage.
module pixel_classifier #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int RUN      = 3,
   parameter int Y_MIN    = 32,
   parameter int FLAG_MIN = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_valid,
   input  logic       pix_sof,
   input  logic [7:0] pix_y,
   input  logic [7:0] pix_cr,
   input  logic [7:0] pix_cb,
   input  logic       thr_we,
   input  logic [3:0] thr_addr,
   input  logic [7:0] thr_data,
   output logic       interesting_flag,
   output logic [9:0] interesting_x,
   output logic [8:0] interesting_y,
   output logic [1:0] color,
   output logic       frame_flag,
   output logic       frame_err
);

   localparam logic [9:0] X_LAST   = 10'(H_ACTIVE - 1);
   localparam logic [8:0] Y_LAST   = 9'(V_ACTIVE - 1);
   localparam logic [7:0] LUMA_MIN = 8'(Y_MIN);
   localparam logic [3:0] RUN_MIN  = 4'(RUN);
   localparam int         HW       = $clog2(FLAG_MIN + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(FLAG_MIN - 1);

   typedef enum logic [1:0] {
      WAIT_SOF,
      ACTIVE,
      DRAIN,
      HOLD
   } state_t;

   state_t state;
   state_t state_d;
   logic   flag_d;
   logic   accept;
   logic   err_set;
   logic   sof_in;
   logic   last;
   logic   new_frame;
   logic   sof_seen;
   logic   out_sof;
   logic [1:0]    drain_cnt;
   logic [HW-1:0] hold_cnt;

   logic [7:0] cr_min [4];
   logic [7:0] cr_max [4];
   logic [7:0] cb_min [4];
   logic [7:0] cb_max [4];
   logic [3:0] match;

   logic [9:0] nx;
   logic [8:0] ny;
   logic [9:0] px;
   logic [8:0] py;

   logic       s1_valid;
   logic       s1_sof;
   logic [3:0] s1_match;
   logic [9:0] s1_x;
   logic [8:0] s1_y;

   logic [1:0] col;
   logic       hit;
   logic [3:0] run;
   logic [3:0] run_d;
   logic [1:0] prev_col;

   logic       s2_valid;
   logic       s2_sof;
   logic       s2_hit;
   logic [9:0] s2_x;
   logic [8:0] s2_y;
   logic [1:0] s2_col;

   assign sof_in  = pix_valid && pix_sof;
   assign px      = pix_sof ? '0 : nx;
   assign py      = pix_sof ? '0 : ny;
   assign out_sof = s2_valid && s2_sof;
   assign last    = state == ACTIVE && pix_valid && !pix_sof
                 && nx == X_LAST && ny == Y_LAST;

   // threshold register file, addressed as {colour, field}
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            cr_min[k] <= 8'hff;
            cr_max[k] <= 8'h00;
            cb_min[k] <= 8'hff;
            cb_max[k] <= 8'h00;
         end
      end else if (thr_we) begin
         unique case (thr_addr[1:0])
            2'd0: cr_min[thr_addr[3:2]] <= thr_data;
            2'd1: cr_max[thr_addr[3:2]] <= thr_data;
            2'd2: cb_min[thr_addr[3:2]] <= thr_data;
            2'd3: cb_max[thr_addr[3:2]] <= thr_data;
         endcase
      end
   end

   // inclusive box test of the incoming pixel against every colour
   always_comb begin
      match = '0;
      for (int k = 0; k < 4; k++) begin
         match[k] = pix_y >= LUMA_MIN
                 && pix_cr >= cr_min[k] && pix_cr <= cr_max[k]
                 && pix_cb >= cb_min[k] && pix_cb <= cb_max[k];
      end
   end

   // frame state register and sticky/housekeeping control
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= WAIT_SOF;
         frame_flag <= 1'b0;
         frame_err  <= 1'b0;
         drain_cnt  <= '0;
         hold_cnt   <= '0;
         new_frame  <= 1'b0;
         sof_seen   <= 1'b0;
      end else begin
         state      <= state_d;
         frame_flag <= flag_d;
         if (err_set) frame_err <= 1'b1;
         drain_cnt  <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
         if (state != HOLD) hold_cnt <= '0;
         else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
         if (state == DRAIN || state == HOLD) begin
            new_frame <= new_frame || sof_in;
            sof_seen  <= sof_seen || out_sof;
         end else begin
            new_frame <= 1'b0;
            sof_seen  <= 1'b0;
         end
      end
   end

   // next state, pixel acceptance and error detection
   always_comb begin
      state_d = state;
      flag_d  = frame_flag;
      accept  = 1'b0;
      err_set = 1'b0;
      unique case (state)
         WAIT_SOF: begin
            accept = sof_in;
            if (sof_in) state_d = ACTIVE;
         end
         ACTIVE: begin
            accept  = pix_valid;
            err_set = sof_in;
            if (last) state_d = DRAIN;
         end
         DRAIN: begin
            accept  = sof_in || (pix_valid && new_frame);
            err_set = pix_valid && (pix_sof ? new_frame : !new_frame);
            if (drain_cnt == 2'd2) begin
               state_d = HOLD;
               flag_d  = 1'b1;
            end
         end
         HOLD: begin
            accept  = sof_in || (pix_valid && new_frame);
            err_set = pix_valid && (pix_sof ? new_frame : !new_frame);
            if (hold_cnt == HOLD_LAST && (sof_seen || out_sof)) begin
               state_d = ACTIVE;
               flag_d  = 1'b0;
            end
         end
      endcase
   end

   // raster coordinate of the next non-sof pixel
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nx <= '0;
         ny <= '0;
      end else if (accept) begin
         if (px == X_LAST) begin
            nx <= '0;
            ny <= py + 9'd1;
         end else begin
            nx <= px + 10'd1;
            ny <= py;
         end
      end
   end

   // stage 1: register the accepted pixel and its match vector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_sof   <= 1'b0;
         s1_match <= '0;
         s1_x     <= '0;
         s1_y     <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_sof   <= pix_sof;
            s1_match <= match;
            s1_x     <= px;
            s1_y     <= py;
         end
      end
   end

   // lowest colour index wins; run restarts at line start or colour change
   always_comb begin
      col = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (s1_match[k]) col = 2'(k);
      end
      hit = |s1_match;
      if (!hit) run_d = 4'd0;
      else if (s1_x == '0 || run == 4'd0 || col != prev_col) run_d = 4'd1;
      else if (run == 4'hf) run_d = run;
      else run_d = run + 4'd1;
   end

   // stage 2: run state and qualified-pixel decision
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run      <= '0;
         prev_col <= '0;
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_hit   <= 1'b0;
         s2_x     <= '0;
         s2_y     <= '0;
         s2_col   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_hit   <= s1_valid && run_d >= RUN_MIN;
         if (s1_valid) begin
            run      <= run_d;
            prev_col <= col;
            s2_sof   <= s1_sof;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            s2_col   <= col;
         end
      end
   end

   // stage 3: output register, muted while the frame window is open
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         interesting_flag <= 1'b0;
         interesting_x    <= '0;
         interesting_y    <= '0;
         color            <= '0;
      end else begin
         interesting_flag <= s2_hit && !flag_d;
         if (s2_hit && !flag_d) begin
            interesting_x <= s2_x;
            interesting_y <= s2_y;
            color         <= s2_col;
         end
      end
   end

endmodule

// File: tb/tb_pixel_classifier.sv
// tb_pixel_classifier: directed frames on a reduced 112x16 raster
// with hand-computed flag lists and frame window timing.
module tb_pixel_classifier;

   localparam int H = 112;
   localparam int V = 16;
   localparam logic [23:0] C0  = {8'd80, 8'd170, 8'd70};
   localparam logic [23:0] C1  = {8'd80, 8'd110, 8'd110};
   localparam logic [23:0] NOM = {8'd80, 8'd0, 8'd0};

   logic       clk = 1'b0;
   logic       reset;
   logic       pix_valid;
   logic       pix_sof;
   logic [7:0] pix_y;
   logic [7:0] pix_cr;
   logic [7:0] pix_cb;
   logic       thr_we;
   logic [3:0] thr_addr;
   logic [7:0] thr_data;
   logic       interesting_flag;
   logic [9:0] interesting_x;
   logic [8:0] interesting_y;
   logic [1:0] color;
   logic       frame_flag;
   logic       frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int ncyc = 0;
   int n_high = 0;
   int n_rise = 0;
   int n_win = 0;
   int rise_cyc = 0;
   int last_cyc = 0;
   logic ff_prev = 1'b0;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];

   pixel_classifier #(
      .H_ACTIVE(H),
      .V_ACTIVE(V),
      .RUN(3),
      .Y_MIN(32),
      .FLAG_MIN(128)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pix_valid(pix_valid),
      .pix_sof(pix_sof),
      .pix_y(pix_y),
      .pix_cr(pix_cr),
      .pix_cb(pix_cb),
      .thr_we(thr_we),
      .thr_addr(thr_addr),
      .thr_data(thr_data),
      .interesting_flag(interesting_flag),
      .interesting_x(interesting_x),
      .interesting_y(interesting_y),
      .color(color),
      .frame_flag(frame_flag),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ncyc <= ncyc + 1;

   // capture emitted pixels and the frame window shape
   always @(negedge clk) begin
      if (interesting_flag) begin
         got_q.push_back({11'd0, interesting_x, interesting_y, color});
         if (frame_flag) n_win <= n_win + 1;
      end
      if (frame_flag) n_high <= n_high + 1;
      if (frame_flag && !ff_prev) begin
         n_rise   <= n_rise + 1;
         rise_cyc <= ncyc;
      end
      ff_prev <= frame_flag;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ent(input int x, input int y,
                                       input int c);
      return {11'd0, 10'(x), 9'(y), 2'(c)};
   endfunction

   task automatic cmp_flags(input string tag);
      chk($sformatf("%s_n", tag), 32'(got_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         chk($sformatf("%s_%0d", tag, i),
             (i < got_q.size()) ? got_q[i] : 32'hffff_ffff, exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_flag"}, 32'(interesting_flag), 32'd0);
      chk({tag, "_x"}, 32'(interesting_x), 32'd0);
      chk({tag, "_y"}, 32'(interesting_y), 32'd0);
      chk({tag, "_color"}, 32'(color), 32'd0);
      chk({tag, "_frame_flag"}, 32'(frame_flag), 32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
   endtask

   task automatic send(input logic v, input logic s,
                       input logic [23:0] p);
      pix_valid = v;
      pix_sof   = s;
      {pix_y, pix_cr, pix_cb} = p;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) send(1'b0, 1'b0, NOM);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      thr_we   = 1'b1;
      thr_addr = a;
      thr_data = d;
      @(posedge clk);
      #1;
      thr_we = 1'b0;
   endtask

   task automatic prog_c0();
      wr(4'd0, 8'd150);
      wr(4'd1, 8'd200);
      wr(4'd2, 8'd50);
      wr(4'd3, 8'd90);
   endtask

   function automatic logic [23:0] pix_a(input int x, input int y);
      if (y == 10 && x >= 100 && x <= 104) return C0;
      if ((y == 4 && x >= H - 2) || (y == 5 && x <= 3)) return C0;
      if (y == 7 && x >= 20 && x <= 23) return C1;
      if (y == 8 && x >= 20 && x <= 23) return {8'd31, 8'd110, 8'd110};
      if (y == 9 && x >= 20 && x <= 22) return {8'd32, 8'd150, 8'd90};
      return NOM;
   endfunction

   initial begin
      reset     = 1'b0;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      {pix_y, pix_cr, pix_cb} = NOM;
      thr_we    = 1'b0;
      thr_addr  = '0;
      thr_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_outs("rst");
      reset = 1'b1;
      @(posedge clk);
      #1;

      prog_c0();
      wr(4'd4, 8'd100);
      wr(4'd5, 8'd120);
      wr(4'd6, 8'd100);
      wr(4'd7, 8'd120);
      wr(4'd12, 8'd90);
      wr(4'd13, 8'd130);
      wr(4'd14, 8'd90);
      wr(4'd15, 8'd130);

      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            send(1'b1, x == 0 && y == 0, pix_a(x, y));
         end
      end
      last_cyc = ncyc;
      idle(9);
      exp_q.push_back(ent(2, 5, 0));
      exp_q.push_back(ent(3, 5, 0));
      exp_q.push_back(ent(22, 7, 1));
      exp_q.push_back(ent(23, 7, 1));
      exp_q.push_back(ent(22, 9, 0));
      exp_q.push_back(ent(102, 10, 0));
      exp_q.push_back(ent(103, 10, 0));
      exp_q.push_back(ent(104, 10, 0));
      cmp_flags("frame_a");

      send(1'b1, 1'b1, C0);
      for (int i = 1; i < 12 * H + 50; i++) begin
         send(1'b1, 1'b0,
              (i < H || (i >= H + 20 && i <= H + 24)) ? C0 : NOM);
      end
      chk("err_pre", 32'(frame_err), 32'd0);
      send(1'b1, 1'b1, C0);
      for (int i = 1; i <= 4; i++) send(1'b1, 1'b0, C0);
      for (int i = 5; i < H + 4; i++) begin
         send(1'b1, 1'b0, (i >= H) ? C1 : NOM);
      end
      idle(2);
      @(negedge clk);
      #1;
      chk("rise_delay", 32'(rise_cyc - last_cyc), 32'd3);
      chk("flag_len", 32'(n_high), 32'd128);
      chk("flags_in_win", 32'(n_win), 32'd0);
      chk("rise_count", 32'(n_rise), 32'd1);
      chk("err_post", 32'(frame_err), 32'd1);
      chk("pre_rst_flag", 32'(interesting_flag), 32'd1);
      reset = 1'b0;
      #1;
      chk_outs("async_rst");
      exp_q.push_back(ent(22, 1, 0));
      exp_q.push_back(ent(23, 1, 0));
      exp_q.push_back(ent(24, 1, 0));
      exp_q.push_back(ent(2, 0, 0));
      exp_q.push_back(ent(3, 0, 0));
      exp_q.push_back(ent(4, 0, 0));
      exp_q.push_back(ent(2, 1, 1));
      exp_q.push_back(ent(3, 1, 1));
      cmp_flags("frame_bc");

      @(posedge clk);
      #1;
      reset = 1'b1;
      prog_c0();
      for (int i = 0; i < 5; i++) send(1'b1, 1'b0, C0);
      idle(4);
      cmp_flags("wait_sof");
      send(1'b1, 1'b1, C0);
      for (int i = 1; i <= 4; i++) send(1'b1, 1'b0, C0);
      idle(4);
      exp_q.push_back(ent(2, 0, 0));
      exp_q.push_back(ent(3, 0, 0));
      exp_q.push_back(ent(4, 0, 0));
      cmp_flags("restart");

      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      send(1'b1, 1'b1, C0);
      for (int i = 1; i <= 4; i++) send(1'b1, 1'b0, C0);
      idle(4);
      cmp_flags("thr_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
